// File: rtl/mil_tx_arbiter_pkg.sv
// rtl/mil_tx_arbiter_pkg.sv - shared types and constants for the 1553 transmit arbiter
package milArbPkg;

    localparam int MIL_WORD_W = 18;

    typedef enum logic [1:0] {
        COMMAND = 2'd0,
        DATA    = 2'd1,
        STATUS  = 2'd2
    } MilWordType;

    typedef struct packed {
        MilWordType  word_type;
        logic [15:0] data;
    } MilWord;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } ArbState;

endpackage

// File: rtl/mil_tx_arbiter_if.sv
// rtl/mil_tx_arbiter_if.sv - requester push ports plus transceiver push port
interface mil_tx_arbiter_if
    import milArbPkg::*;
#(
    parameter int NREQ = 2
) ();

    logic [NREQ-1:0]            in_request;
    logic [NREQ*MIL_WORD_W-1:0] in_data;
    logic [NREQ-1:0]            in_last;
    logic [NREQ-1:0]            in_done;
    logic                       out_request;
    logic [MIL_WORD_W-1:0]      out_data;
    logic                       out_done;

    // slave: the arbiter's view; master: requesters and transceiver around it
    modport slave (
        input  in_request, in_data, in_last, out_done,
        output in_done, out_request, out_data
    );

    modport master (
        output in_request, in_data, in_last, out_done,
        input  in_done, out_request, out_data
    );

endinterface

// File: rtl/mil_arb_rr_pick.sv
// rtl/mil_arb_rr_pick.sv - combinational round-robin picker starting at ptr
module mil_arb_rr_pick
    import milArbPkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         request,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NREQ);

    // Scan from the farthest offset down so the nearest requester after ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (request[(int'(ptr) + i) % NREQ]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mil_tx_arbiter.sv
// rtl/mil_tx_arbiter.sv - message-atomic round-robin arbiter for the 1553 transmit push port
// Define MILARB_TIMEOUT_EN to add the stalled-owner watchdog.
module mil_tx_arbiter
    import milArbPkg::*;
#(
    parameter int NREQ           = 2,
    parameter int GAP_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    mil_tx_arbiter_if.slave         bus,
    output logic                    grant_valid,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    timeout_abort
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    ArbState          state, state_d;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0] grant_idx_d;
    logic             grant_valid_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] next_ptr;
    logic             cur_req;
    logic             cur_last;
    logic             release_grant;
    logic             expire;

    mil_arb_rr_pick #(.NREQ(NREQ)) u_pick (
        .request (bus.in_request),
        .ptr     (rr_ptr),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    assign cur_req  = bus.in_request[grant_idx];
    assign cur_last = bus.in_last[grant_idx];
    assign next_ptr = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef MILARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt, stall_cnt_d;

    assign expire = !cur_req && (stall_cnt >= STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            grant_idx   <= grant_idx_d;
            grant_valid <= grant_valid_d;
            gap_cnt     <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d         = state;
        rr_ptr_d        = rr_ptr;
        grant_idx_d     = grant_idx;
        grant_valid_d   = grant_valid;
        gap_cnt_d       = gap_cnt;
        release_grant   = 1'b0;
        timeout_abort   = 1'b0;
        bus.out_request = 1'b0;
        bus.out_data    = '0;
        bus.in_done     = '0;
`ifdef MILARB_TIMEOUT_EN
        stall_cnt_d     = stall_cnt;
`endif

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d       = BUSY;
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
`ifdef MILARB_TIMEOUT_EN
                    stall_cnt_d   = '0;
`endif
                end
            end

            BUSY: begin
                bus.out_request        = cur_req;
                bus.out_data           = bus.in_data[int'(grant_idx) * MIL_WORD_W +: MIL_WORD_W];
                bus.in_done[grant_idx] = bus.out_done;
`ifdef MILARB_TIMEOUT_EN
                if (cur_req) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt < STALL_W'(TIMEOUT_CYCLES)) begin
                    stall_cnt_d = stall_cnt + STALL_W'(1);
                end
`endif
                // A completing word wins over a coincident watchdog expiry.
                if (bus.out_done && cur_last) begin
                    release_grant = 1'b1;
                end else if (expire && !bus.out_done) begin
                    timeout_abort = 1'b1;
                    release_grant = 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (release_grant) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = next_ptr;
            gap_cnt_d     = GAP_W'(GAP_CYCLES);
            state_d       = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
    end

endmodule

// File: tb/tb_mil_tx_arbiter.sv
// tb/tb_mil_tx_arbiter.sv - directed self-checking bench for mil_tx_arbiter
module tb_mil_tx_arbiter;
    import milArbPkg::*;

    localparam int W = MIL_WORD_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       ga_valid, a_to, gb_valid, b_to;
    logic [0:0] ga_idx;
    logic [1:0] gb_idx;
    int         checks = 0;
    int         passes = 0;

    mil_tx_arbiter_if #(.NREQ(2)) bus_a ();
    mil_tx_arbiter_if #(.NREQ(3)) bus_b ();

    mil_tx_arbiter #(.NREQ(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(10)) dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .bus           (bus_a),
        .grant_valid   (ga_valid),
        .grant_idx     (ga_idx),
        .timeout_abort (a_to)
    );

    mil_tx_arbiter #(.NREQ(3), .GAP_CYCLES(0), .TIMEOUT_CYCLES(10)) dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .bus           (bus_b),
        .grant_valid   (gb_valid),
        .grant_idx     (gb_idx),
        .timeout_abort (b_to)
    );

    // sa: {valid, idx, out_request, in_done, timeout}; qa: same without idx
    logic [5:0] sa;
    logic [4:0] qa;
    logic [6:0] sb;
    logic [4:0] qb;
    assign sa = {ga_valid, ga_idx, bus_a.out_request, bus_a.in_done, a_to};
    assign qa = {ga_valid, bus_a.out_request, bus_a.in_done, a_to};
    assign sb = {gb_valid, gb_idx, bus_b.out_request, bus_b.in_done};
    assign qb = {gb_valid, bus_b.out_request, bus_b.in_done, b_to};

    function automatic logic [W-1:0] mk(MilWordType t, logic [15:0] d);
        MilWord m;
        m.word_type = t;
        m.data      = d;
        return m;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        bus_a.in_request = '0;
        bus_a.in_last    = '0;
        bus_a.out_done   = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.in_request = '1;
        bus_a.in_data    = {mk(DATA, 16'h1111), mk(COMMAND, 16'h2222)};
        bus_a.in_last    = '1;
        bus_a.out_done   = 1'b1;
        bus_b.in_request = '1;
        bus_b.in_data    = {mk(DATA, 16'h3333), mk(DATA, 16'h4444), mk(STATUS, 16'h5555)};
        bus_b.in_last    = '1;
        bus_b.out_done   = 1'b1;
        cyc();
        cyc();
        checks++; if (qa !== 5'b0) $display("FAIL reset_a_ctrl: got %b expected 00000", qa); else passes++;
        checks++; if (bus_a.out_data !== '0) $display("FAIL reset_a_data: got %h expected 0", bus_a.out_data); else passes++;
        checks++; if (qb !== 5'b0) $display("FAIL reset_b_ctrl: got %b expected 00000", qb); else passes++;
        checks++; if (bus_b.out_data !== '0) $display("FAIL reset_b_data: got %h expected 0", bus_b.out_data); else passes++;
        bus_a.in_request = '0;
        bus_a.in_last    = '0;
        bus_a.out_done   = 1'b0;
        rst_a = 1'b1;
        cyc();
        #1;
        checks++; if (qa !== 5'b0) $display("FAIL reset_a_idle: got %b expected 00000", qa); else passes++;
    endtask

    task automatic test_single();
        logic [W-1:0] w [4];
        w[0] = mk(COMMAND, 16'hA5C3);
        w[1] = mk(DATA, 16'h1234);
        w[2] = mk(DATA, 16'hBEEF);
        w[3] = mk(COMMAND, 16'h0F0F);
        cyc();
        bus_a.in_request = 2'b01;
        bus_a.in_data[0 +: W] = w[0];
        #1;
        checks++; if (qa !== 5'b0) $display("FAIL single_latency: got %b expected 00000", qa); else passes++;
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus_a.in_data[0 +: W] = w[k];
            bus_a.in_last = (k == 2) ? 2'b01 : 2'b00;
            bus_a.out_done = 1'b1;
            #1;
            checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0}) $display("FAIL single_word%0d_ctrl: got %b expected 101010", k, sa); else passes++;
            checks++; if (bus_a.out_data !== w[k]) $display("FAIL single_word%0d_data: got %h expected %h", k, bus_a.out_data, w[k]); else passes++;
        end
        // Next message is presented at once; the gap must hold it back for GAP+1 cycles.
        for (int g = 0; g < 5; g++) begin
            cyc();
            if (g == 0) bus_a.in_data[0 +: W] = w[3];
            #1;
            checks++; if (qa !== 5'b0) $display("FAIL single_gap%0d: got %b expected 00000", g, qa); else passes++;
        end
        cyc();
        #1;
        checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0}) $display("FAIL b2b_ctrl: got %b expected 101010", sa); else passes++;
        checks++; if (bus_a.out_data !== w[3]) $display("FAIL b2b_data: got %h expected %h", bus_a.out_data, w[3]); else passes++;
        cyc();
        drain_a();
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] v0, v1, u0;
        v0 = mk(COMMAND, 16'h7001);
        v1 = mk(DATA, 16'h7002);
        u0 = mk(STATUS, 16'h8001);
        rst_a = 1'b0;
        cyc();
        rst_a = 1'b1;
        cyc();
        bus_a.in_request = 2'b11;
        bus_a.in_data    = {u0, v0};
        bus_a.in_last    = 2'b10;
        bus_a.out_done   = 1'b0;
        #1;
        checks++; if (qa !== 5'b0) $display("FAIL simul_idle: got %b expected 00000", qa); else passes++;
        cyc();
        bus_a.out_done = 1'b1;
        #1;
        checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0}) $display("FAIL simul_r0_w0: got %b expected 101010", sa); else passes++;
        checks++; if (bus_a.out_data !== v0) $display("FAIL simul_r0_w0_data: got %h expected %h", bus_a.out_data, v0); else passes++;
        cyc();
        bus_a.in_data[0 +: W] = v1;
        bus_a.in_last = 2'b11;
        #1;
        checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0}) $display("FAIL simul_r0_w1: got %b expected 101010", sa); else passes++;
        checks++; if (bus_a.out_data !== v1) $display("FAIL simul_r0_w1_data: got %h expected %h", bus_a.out_data, v1); else passes++;
        for (int g = 0; g < 5; g++) begin
            cyc();
            if (g == 0) begin
                bus_a.in_request = 2'b10;
                bus_a.in_last    = 2'b10;
            end
            #1;
            checks++; if (qa !== 5'b0) $display("FAIL simul_hold%0d: got %b expected 00000", g, qa); else passes++;
        end
        cyc();
        #1;
        checks++; if (sa !== {1'b1, 1'b1, 1'b1, 2'b10, 1'b0}) $display("FAIL simul_r1: got %b expected 111100", sa); else passes++;
        checks++; if (bus_a.out_data !== u0) $display("FAIL simul_r1_data: got %h expected %h", bus_a.out_data, u0); else passes++;
        cyc();
        drain_a();
    endtask

    task automatic test_mid_message();
        logic [W-1:0] x0, x1, y0;
        x0 = mk(COMMAND, 16'h9001);
        x1 = mk(DATA, 16'h9002);
        y0 = mk(DATA, 16'hC0DE);
        cyc();
        bus_a.in_request = 2'b01;
        bus_a.in_data    = {mk(DATA, 16'h0000), x0};
        bus_a.in_last    = 2'b00;
        bus_a.out_done   = 1'b1;
        cyc();
        #1;
        checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0}) $display("FAIL mid_r0_w0: got %b expected 101010", sa); else passes++;
        cyc();
        bus_a.in_request = 2'b11;
        bus_a.in_data    = {y0, x1};
        bus_a.in_last    = 2'b11;
        #1;
        checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0}) $display("FAIL mid_no_interleave: got %b expected 101010", sa); else passes++;
        checks++; if (bus_a.out_data !== x1) $display("FAIL mid_r0_w1_data: got %h expected %h", bus_a.out_data, x1); else passes++;
        for (int g = 0; g < 5; g++) begin
            cyc();
            if (g == 0) bus_a.in_request = 2'b10;
            #1;
            checks++; if (qa !== 5'b0) $display("FAIL mid_gap%0d: got %b expected 00000", g, qa); else passes++;
        end
        cyc();
        #1;
        checks++; if (sa !== {1'b1, 1'b1, 1'b1, 2'b10, 1'b0}) $display("FAIL mid_r1_after_gap: got %b expected 111100", sa); else passes++;
        checks++; if (bus_a.out_data !== y0) $display("FAIL mid_r1_data: got %h expected %h", bus_a.out_data, y0); else passes++;
        cyc();
        drain_a();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] p0, q0, q1;
        p0 = mk(COMMAND, 16'h5A01);
        q0 = mk(COMMAND, 16'h6B01);
        q1 = mk(DATA, 16'h6B02);
        cyc();
        bus_a.in_request = 2'b01;
        bus_a.in_data    = {q0, mk(DATA, 16'h4242)};
        bus_a.in_last    = 2'b01;
        bus_a.out_done   = 1'b1;
        cyc();
        #1;
        checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0}) $display("FAIL rst_pre_r0: got %b expected 101010", sa); else passes++;
        cyc();
        bus_a.in_request = 2'b11;
        bus_a.in_data    = {q0, p0};
        bus_a.in_last    = 2'b00;
        repeat (4) cyc();
        cyc();
        #1;
        checks++; if (sa !== {1'b1, 1'b1, 1'b1, 2'b10, 1'b0}) $display("FAIL rst_rr_ptr1: got %b expected 111100", sa); else passes++;
        cyc();
        bus_a.in_data[W +: W] = q1;
        bus_a.out_done = 1'b0;
        #1;
        checks++; if (sa !== {1'b1, 1'b1, 1'b1, 2'b00, 1'b0}) $display("FAIL rst_word2_ctrl: got %b expected 111000", sa); else passes++;
        checks++; if (bus_a.out_data !== q1) $display("FAIL rst_word2_data: got %h expected %h", bus_a.out_data, q1); else passes++;
        #2;
        rst_a = 1'b0;
        #1;
        checks++; if (qa !== 5'b0) $display("FAIL rst_async_drop: got %b expected 00000", qa); else passes++;
        checks++; if (bus_a.out_data !== '0) $display("FAIL rst_async_data: got %h expected 0", bus_a.out_data); else passes++;
        cyc();
        rst_a = 1'b1;
        bus_a.in_data[W +: W] = q0;
        #1;
        checks++; if (qa !== 5'b0) $display("FAIL rst_release_idle: got %b expected 00000", qa); else passes++;
        cyc();
        #1;
        checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b00, 1'b0}) $display("FAIL rst_regrant0: got %b expected 101000", sa); else passes++;
        checks++; if (bus_a.out_data !== p0) $display("FAIL rst_regrant0_data: got %h expected %h", bus_a.out_data, p0); else passes++;
        bus_a.in_last  = 2'b01;
        bus_a.out_done = 1'b1;
        cyc();
        drain_a();
    endtask

`ifdef MILARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [W-1:0] s0;
        s0 = mk(STATUS, 16'hD00D);
        cyc();
        bus_a.in_request = 2'b01;
        bus_a.in_data    = {s0, mk(COMMAND, 16'hE001)};
        bus_a.in_last    = 2'b00;
        bus_a.out_done   = 1'b0;
        cyc();
        bus_a.out_done = 1'b1;
        #1;
        checks++; if (sa !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0}) $display("FAIL to_w1: got %b expected 101010", sa); else passes++;
        for (int s = 1; s <= 10; s++) begin
            cyc();
            if (s == 1) begin
                bus_a.in_request = 2'b10;
                bus_a.in_last    = 2'b10;
                bus_a.out_done   = 1'b0;
            end
            #1;
            checks++; if (sa !== {1'b1, 1'b0, 1'b0, 2'b00, (s == 10)}) $display("FAIL to_stall%0d: got %b expected %b", s, sa, {1'b1, 1'b0, 1'b0, 2'b00, (s == 10)}); else passes++;
        end
        for (int g = 0; g < 5; g++) begin
            cyc();
            if (g == 0) bus_a.out_done = 1'b1;
            #1;
            checks++; if (qa !== 5'b0) $display("FAIL to_gap%0d: got %b expected 00000", g, qa); else passes++;
        end
        cyc();
        #1;
        checks++; if (sa !== {1'b1, 1'b1, 1'b1, 2'b10, 1'b0}) $display("FAIL to_regrant1: got %b expected 111100", sa); else passes++;
        checks++; if (bus_a.out_data !== s0) $display("FAIL to_regrant1_data: got %h expected %h", bus_a.out_data, s0); else passes++;
        cyc();
        drain_a();
    endtask
`endif

    task automatic test_rr3();
        logic [W-1:0] dd [3];
        logic [1:0]   ei;
        logic [2:0]   eo;
        dd[0] = mk(COMMAND, 16'h0A00);
        dd[1] = mk(DATA, 16'h0B01);
        dd[2] = mk(STATUS, 16'h0C02);
        bus_b.in_request = 3'b111;
        bus_b.in_data    = {dd[2], dd[1], dd[0]};
        bus_b.in_last    = 3'b111;
        bus_b.out_done   = 1'b1;
        cyc();
        rst_b = 1'b1;
        #1;
        checks++; if (qb !== 5'b0) $display("FAIL rr3_idle: got %b expected 00000", qb); else passes++;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            #1;
            if (k % 2 == 1) begin
                ei = 2'(((k - 1) / 2) % 3);
                eo = 3'b001 << ei;
                checks++; if (sb !== {1'b1, ei, 1'b1, eo}) $display("FAIL rr3_grant_k%0d: got %b expected %b", k, sb, {1'b1, ei, 1'b1, eo}); else passes++;
                checks++; if (bus_b.out_data !== dd[ei]) $display("FAIL rr3_data_k%0d: got %h expected %h", k, bus_b.out_data, dd[ei]); else passes++;
            end else begin
                checks++; if (qb !== 5'b0) $display("FAIL rr3_idle_k%0d: got %b expected 00000", k, qb); else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_mid_message();
        test_reset_mid();
`ifdef MILARB_TIMEOUT_EN
        test_timeout();
`endif
        test_rr3();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary, got timeout expected finish");
        $fatal(1);
    end

endmodule
